// File: rtl/lsu.sv
// Load/store unit: single outstanding access, IDLE/REQ/WAIT bus handshake,
// byte/half/word formatting with alignment checks and a response timeout.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [4:0]  req_rd_i,
  output logic        rsp_valid_o,
  output logic [4:0]  rsp_rd_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      r_state, w_next;
  logic        r_we, r_unsigned;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  logic [4:0]  r_rd;
  logic [CW-1:0] r_cnt;
  logic        r_rsp_valid, r_rsp_err;
  logic [4:0]  r_rsp_rd;
  logic [31:0] r_rsp_data;

  logic        w_accept, w_misalign, w_timeout, w_busy;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shifted, w_load;

  assign w_accept  = req_valid_i && (r_state == S_IDLE);
  assign w_misalign = (req_size_i == 2'b11) ||
                      ((req_size_i == 2'b01) && req_addr_i[0]) ||
                      ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
  assign w_busy    = (r_state != S_IDLE);
  // counter reaches TIMEOUT_CYCLES on the edge where this is true
  assign w_timeout = w_busy && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && !w_misalign) w_next = S_REQ;
      S_REQ:  if (w_timeout) w_next = S_IDLE;
              else if (mem_gnt_i) w_next = S_WAIT;
      S_WAIT: if (mem_rvalid_i || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0; r_unsigned <= 1'b0; r_addr <= '0; r_wdata <= '0;
      r_size <= '0; r_rd <= '0; r_cnt <= '0;
    end else if (w_accept) begin
      r_we <= req_we_i; r_unsigned <= req_unsigned_i; r_addr <= req_addr_i;
      r_wdata <= req_wdata_i; r_size <= req_size_i; r_rd <= req_rd_i; r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_shifted = mem_rdata_i >> {r_addr[1:0], 3'b000};
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'h0, w_shifted[7:0]}  : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = r_unsigned ? {16'h0, w_shifted[15:0]} : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0; r_rsp_err <= 1'b0; r_rsp_rd <= '0; r_rsp_data <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept && w_misalign) begin
        r_rsp_valid <= 1'b1; r_rsp_err <= 1'b1; r_rsp_rd <= '0; r_rsp_data <= '0;
      end else if ((r_state == S_WAIT) && mem_rvalid_i) begin
        r_rsp_valid <= 1'b1; r_rsp_err <= 1'b0;
        r_rsp_rd    <= r_we ? 5'd0 : r_rd;
        r_rsp_data  <= r_we ? 32'd0 : w_load;
      end else if (w_timeout) begin
        r_rsp_valid <= 1'b1; r_rsp_err <= 1'b1; r_rsp_rd <= '0; r_rsp_data <= '0;
      end
    end
  end

  always_comb begin
    case (r_size)
      2'b00:   begin w_be = 4'b0001 << r_addr[1:0]; w_wdata = {4{r_wdata[7:0]}};  end
      2'b01:   begin w_be = 4'b0011 << r_addr[1:0]; w_wdata = {2{r_wdata[15:0]}}; end
      default: begin w_be = 4'b1111;                w_wdata = r_wdata;            end
    endcase
  end

  // bus fields are driven only while requesting so they read 0 from reset
  always_comb begin
    req_ready_o = (r_state == S_IDLE);
    busy_o      = w_busy;
    mem_req_o   = (r_state == S_REQ);
    mem_we_o    = mem_req_o & r_we;
    mem_addr_o  = mem_req_o ? {r_addr[31:2], 2'b00} : '0;
    mem_be_o    = mem_req_o ? w_be : '0;
    mem_wdata_o = mem_req_o ? w_wdata : '0;
    rsp_valid_o = r_rsp_valid;
    rsp_err_o   = r_rsp_err;
    rsp_rd_o    = r_rsp_rd;
    rsp_data_o  = r_rsp_data;
  end

endmodule
